// File: rtl/data_island_scheduler_if.sv
// Pixel-position inputs and island control outputs shared by the timing
// generator side (master) and the data island scheduler (slave).
interface data_island_scheduler_if #(
    parameter int BIT_WIDTH  = 10,
    parameter int BIT_HEIGHT = 10
);
    logic [BIT_WIDTH-1:0]  cx;
    logic [BIT_HEIGHT-1:0] cy;
    logic                  island_enable;
    logic [2:0]            mode;
    logic                  island_preamble;
    logic                  packet_enable;
    logic [4:0]            packet_pixel_counter;
    logic                  video_field_end;

    modport master (
        output cx, cy, island_enable,
        input  mode, island_preamble, packet_enable, packet_pixel_counter, video_field_end
    );

    modport slave (
        input  cx, cy, island_enable,
        output mode, island_preamble, packet_enable, packet_pixel_counter, video_field_end
    );
endinterface

// File: rtl/data_island_scheduler.sv
// Opens one fixed-length HDMI data island per line inside horizontal blanking:
// preamble, leading guard, N packet slots of 32 pixels, trailing guard.
module data_island_scheduler #(
    parameter int BIT_WIDTH     = 10,
    parameter int BIT_HEIGHT    = 10,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int FRAME_WIDTH   = 800,
    parameter int ISLAND_OFFSET = 4,
    parameter int MAX_PACKETS   = 18
) (
    input logic clk_pixel,
    input logic reset,
    data_island_scheduler_if.slave bus
);
    localparam int AVAIL = (FRAME_WIDTH - SCREEN_WIDTH - ISLAND_OFFSET - 22) / 32;
    localparam int N     = (AVAIL < MAX_PACKETS) ? AVAIL : MAX_PACKETS;
    localparam int PKT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [BIT_WIDTH-1:0]  ISLAND_START = BIT_WIDTH'(SCREEN_WIDTH + ISLAND_OFFSET);
    localparam logic [BIT_WIDTH-1:0]  LAST_COL     = BIT_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [BIT_HEIGHT-1:0] LAST_LINE    = BIT_HEIGHT'(SCREEN_HEIGHT - 1);
    localparam logic [PKT_W-1:0]      LAST_PKT     = PKT_W'(N - 1);

    generate
        if (N < 1) begin : g_no_room
            $error("data_island_scheduler: horizontal blanking too short for any packet");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        LEAD_GUARD,
        PACKET,
        TRAIL_GUARD
    } state_t;

    state_t           state, state_n;
    logic [4:0]       cnt, cnt_n;
    logic [PKT_W-1:0] pkt, pkt_n;

    logic [2:0] mode_q, mode_n;
    logic       preamble_q, preamble_n;
    logic       pe_q, pe_n;
    logic [4:0] ppc_q, ppc_n;
    logic       vfe_q;

    // Outputs are decoded from the next state, so the registered value lines
    // up with the cx sampled on the same edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 5'd1;
        pkt_n   = pkt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (bus.cx == ISLAND_START && bus.island_enable) begin
                    state_n = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (cnt == 5'd7) begin
                    state_n = LEAD_GUARD;
                    cnt_n   = '0;
                end
            end
            LEAD_GUARD: begin
                if (cnt == 5'd1) begin
                    state_n = PACKET;
                    cnt_n   = '0;
                    pkt_n   = '0;
                end
            end
            PACKET: begin
                if (cnt == 5'd31) begin
                    if (pkt == LAST_PKT) begin
                        state_n = TRAIL_GUARD;
                        cnt_n   = '0;
                    end else begin
                        pkt_n = pkt + PKT_W'(1);
                    end
                end
            end
            TRAIL_GUARD: begin
                if (cnt == 5'd1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        mode_n     = 3'd0;
        preamble_n = 1'b0;
        pe_n       = 1'b0;
        ppc_n      = '0;
        case (state_n)
            PREAMBLE:    preamble_n = 1'b1;
            LEAD_GUARD: begin
                mode_n = 3'd4;
                pe_n   = (cnt_n == 5'd1);
            end
            PACKET: begin
                mode_n = 3'd3;
                ppc_n  = cnt_n;
                pe_n   = (cnt_n == 5'd31) && (pkt_n != LAST_PKT);
            end
            TRAIL_GUARD: mode_n = 3'd4;
            default:     mode_n = 3'd0;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            pkt        <= '0;
            mode_q     <= 3'd0;
            preamble_q <= 1'b0;
            pe_q       <= 1'b0;
            ppc_q      <= '0;
            vfe_q      <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pkt        <= pkt_n;
            mode_q     <= mode_n;
            preamble_q <= preamble_n;
            pe_q       <= pe_n;
            ppc_q      <= ppc_n;
            vfe_q      <= (bus.cx == LAST_COL) && (bus.cy == LAST_LINE);
        end
    end

    assign bus.mode                 = mode_q;
    assign bus.island_preamble      = preamble_q;
    assign bus.packet_enable        = pe_q;
    assign bus.packet_pixel_counter = ppc_q;
    assign bus.video_field_end      = vfe_q;
endmodule
